// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encoding and counter sizing.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package usr_pkg;

    // Operation select encoding; 3'b110 and 3'b111 are reserved and behave as HOLD.
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHR  = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ROR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;

    // Shift counter width: must hold 0..width-1 and leave headroom for width itself.
    function automatic int cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    // True for every mode that moves bits (and therefore advances the frame counter).
    function automatic logic is_shift(input logic [2:0] mode);
        return (mode == MODE_SHR) || (mode == MODE_SHL) ||
               (mode == MODE_ROR) || (mode == MODE_ROL);
    endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle between a driver and the universal shift register.
// Latency: none (plain wires).
// Backpressure: none; the register accepts an operation on every enabled clock.
interface univ_shift_reg_if #(
    parameter int WIDTH = 8
) ();
    import usr_pkg::*;

    logic                      en;
    logic [2:0]                mode;
    logic                      sin_msb;
    logic                      sin_lsb;
    logic [WIDTH-1:0]          pdin;
    logic [WIDTH-1:0]          pout;
    logic                      sout_lsb;
    logic                      sout_msb;
    logic [cnt_w(WIDTH)-1:0]   shift_cnt;
    logic                      frame_done;

    modport master (
        output en, mode, sin_msb, sin_lsb, pdin,
        input  pout, sout_lsb, sout_msb, shift_cnt, frame_done
    );

    modport slave (
        input  en, mode, sin_msb, sin_lsb, pdin,
        output pout, sout_lsb, sout_msb, shift_cnt, frame_done
    );

endinterface

// File: rtl/usr_frame_cnt.sv
// Counts shifts since the last load/reset and pulses done after every WIDTH-th shift.
// Latency: 1 cycle; done is high for the single cycle following the wrapping shift.
// Backpressure: none; en low freezes the count and forces done low.
module usr_frame_cnt
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     shift,
    input  logic                     load,
    output logic [cnt_w(WIDTH)-1:0]  cnt,
    output logic                     done
);
    localparam int              CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_done;
    logic          w_wrap;

    // A shift taken at the last position closes the frame.
    assign w_wrap = shift && (r_cnt == LAST);

    // Count register and one-cycle frame pulse; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!en) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_wrap;
            if (load || w_wrap) begin
                r_cnt <= '0;
            end else if (shift) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign cnt  = r_cnt;
    assign done = r_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register (hold/shift/rotate/load) with optional frame counter (USR_FRAME_CNT_EN).
// Latency: 1 cycle from enabled clock edge to pout/sout_*; outputs come straight from q.
// Backpressure: none; en low holds q and count, frame_done reads 0.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    univ_shift_reg_if.slave    bus
);
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;

    // Next register value for the selected operation; reserved codes hold.
    always_comb begin
        w_q_nxt = r_q;
        case (bus.mode)
            MODE_SHR:  w_q_nxt = {bus.sin_msb, r_q[WIDTH-1:1]};
            MODE_SHL:  w_q_nxt = {r_q[WIDTH-2:0], bus.sin_lsb};
            MODE_LOAD: w_q_nxt = bus.pdin;
            MODE_ROR:  w_q_nxt = {r_q[0], r_q[WIDTH-1:1]};
            MODE_ROL:  w_q_nxt = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
            default:   w_q_nxt = r_q;
        endcase
    end

    // Data register: synchronous clear wins over enable and mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (bus.en) begin
            r_q <= w_q_nxt;
        end
    end

    assign bus.pout     = r_q;
    assign bus.sout_lsb = r_q[0];
    assign bus.sout_msb = r_q[WIDTH-1];

`ifdef USR_FRAME_CNT_EN
    logic w_shift;
    logic w_load;

    assign w_shift = is_shift(bus.mode);
    assign w_load  = (bus.mode == MODE_LOAD);

    usr_frame_cnt #(
        .WIDTH (WIDTH)
    ) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (bus.en),
        .shift (w_shift),
        .load  (w_load),
        .cnt   (bus.shift_cnt),
        .done  (bus.frame_done)
    );
`else
    assign bus.shift_cnt  = '0;
    assign bus.frame_done = 1'b0;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: a 4-bit and an 8-bit instance driven in lockstep.
// Latency expected: results visible 1 cycle after each enabled edge.
// Backpressure: none exercised beyond the enable input.
module tb_univ_shift_reg;
    import usr_pkg::*;

`ifdef USR_FRAME_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    univ_shift_reg_if #(.WIDTH(4)) bus4 ();
    univ_shift_reg_if #(.WIDTH(8)) bus8 ();

    univ_shift_reg #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    univ_shift_reg #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: register value, shifts since last load/reset, pulse flag.
    logic [63:0] m_q [2];
    int          m_sh [2];
    bit          m_done [2];
    int          m_w [2] = '{4, 8};

    function automatic logic [63:0] nq(int w, logic [63:0] q, logic [2:0] md,
                                       bit smsb, bit slsb, logic [63:0] pd);
        logic [63:0] mask;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (md)
            3'd1:    return ((q >> 1) | (64'(smsb) << (w - 1))) & mask;
            3'd2:    return ((q << 1) | 64'(slsb)) & mask;
            3'd3:    return pd & mask;
            3'd4:    return ((q >> 1) | ((q & 64'd1) << (w - 1))) & mask;
            3'd5:    return ((q << 1) | (q >> (w - 1))) & mask;
            default: return q;
        endcase
    endfunction

    function automatic int e_cnt(int i);
        return CNT_ON ? (m_sh[i] % m_w[i]) : 0;
    endfunction

    function automatic bit e_done(int i);
        return CNT_ON ? m_done[i] : 1'b0;
    endfunction

    task automatic step(bit r, bit e, logic [2:0] md, bit smsb, bit slsb, logic [63:0] pd);
        rst          = r;
        bus4.en      = e;  bus8.en      = e;
        bus4.mode    = md; bus8.mode    = md;
        bus4.sin_msb = smsb; bus8.sin_msb = smsb;
        bus4.sin_lsb = slsb; bus8.sin_lsb = slsb;
        bus4.pdin    = pd[3:0];
        bus8.pdin    = pd[7:0];
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_q[i] = '0; m_sh[i] = 0; m_done[i] = 1'b0;
            end else if (!e) begin
                m_done[i] = 1'b0;
            end else begin
                m_done[i] = 1'b0;
                if (md inside {3'd1, 3'd2, 3'd4, 3'd5}) begin
                    m_sh[i]++;
                    if (m_sh[i] % m_w[i] == 0) m_done[i] = 1'b1;
                end
                if (md == 3'd3) m_sh[i] = 0;
                m_q[i] = nq(m_w[i], m_q[i], md, smsb, slsb, pd);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] c;
        step(1, 0, MODE_SHR, 1, 1, '1);
        c = bus4.shift_cnt;
        n_cmp += 3;
        if (bus4.pout !== 4'b0000) begin n_bad++; $display("FAIL reset_q got=%b want=0000", bus4.pout); end
        if (c !== 7'd0) begin n_bad++; $display("FAIL reset_cnt got=%0d want=0", c); end
        if (bus4.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", bus4.frame_done); end
        step(0, 1, MODE_LOAD, 0, 0, 64'hAA);
        step(1, 1, MODE_LOAD, 1, 1, 64'hFF);
        n_cmp++;
        if (bus4.pout !== 4'b0000) begin n_bad++; $display("FAIL reset_over_load got=%b want=0000", bus4.pout); end
    endtask

    task automatic test_shr_serial();
        bit   sin [4]  = '{1, 0, 1, 1};
        logic lsb [4]  = '{0, 0, 0, 1};
        logic [6:0] c;
        step(1, 0, MODE_HOLD, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, MODE_SHR, sin[k], 0, 0);
            c = bus4.shift_cnt;
            n_cmp += 3;
            if (bus4.sout_lsb !== lsb[k]) begin n_bad++; $display("FAIL shr_sout edge=%0d got=%b want=%b", k + 1, bus4.sout_lsb, lsb[k]); end
            if (bus4.frame_done !== e_done(0)) begin n_bad++; $display("FAIL shr_done edge=%0d got=%b want=%b", k + 1, bus4.frame_done, e_done(0)); end
            if (c !== 7'(e_cnt(0))) begin n_bad++; $display("FAIL shr_cnt edge=%0d got=%0d want=%0d", k + 1, c, e_cnt(0)); end
        end
        n_cmp += 2;
        if (bus4.pout !== 4'b1101) begin n_bad++; $display("FAIL shr_q got=%b want=1101", bus4.pout); end
        if (bus4.frame_done !== CNT_ON) begin n_bad++; $display("FAIL shr_frame got=%b want=%b", bus4.frame_done, CNT_ON); end
        step(0, 1, MODE_HOLD, 0, 0, 0);
        n_cmp++;
        if (bus4.frame_done !== 1'b0) begin n_bad++; $display("FAIL shr_pulse_width got=%b want=0", bus4.frame_done); end
    endtask

    task automatic test_rotate();
        logic [3:0] exp [4] = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
        int pulses = 0;
        logic [6:0] c;
        step(0, 1, MODE_LOAD, 0, 0, 64'b1001);
        for (int k = 0; k < 4; k++) begin
            step(0, 1, MODE_ROL, 0, 0, 0);
            if (bus4.frame_done === 1'b1) pulses++;
            n_cmp++;
            if (bus4.pout !== exp[k]) begin n_bad++; $display("FAIL rol_q step=%0d got=%b want=%b", k, bus4.pout, exp[k]); end
        end
        step(0, 1, MODE_ROR, 0, 0, 0);
        if (bus4.frame_done === 1'b1) pulses++;
        c = bus4.shift_cnt;
        n_cmp += 3;
        if (pulses !== int'(CNT_ON)) begin n_bad++; $display("FAIL rol_pulses got=%0d want=%0d", pulses, int'(CNT_ON)); end
        if (bus4.pout !== 4'b1100) begin n_bad++; $display("FAIL ror_q got=%b want=1100", bus4.pout); end
        if (c !== 7'(CNT_ON ? 1 : 0)) begin n_bad++; $display("FAIL ror_cnt got=%0d want=%0d", c, CNT_ON ? 1 : 0); end
    endtask

    task automatic test_enable();
        logic [3:0] held;
        step(1, 1, MODE_HOLD, 0, 0, 0);
        step(0, 1, MODE_SHL, 0, 1, 0);
        step(0, 1, MODE_SHL, 0, 1, 0);
        held = bus4.pout;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, MODE_SHL, 1, 1, 64'hF);
            n_cmp += 2;
            if (bus4.pout !== held) begin n_bad++; $display("FAIL en_hold_q cyc=%0d got=%b want=%b", k, bus4.pout, held); end
            if (bus4.frame_done !== 1'b0) begin n_bad++; $display("FAIL en_hold_done cyc=%0d got=%b want=0", k, bus4.frame_done); end
        end
        step(0, 1, MODE_SHL, 0, 1, 0);
        n_cmp++;
        if (bus4.frame_done !== 1'b0) begin n_bad++; $display("FAIL en_early_done got=%b want=0", bus4.frame_done); end
        step(0, 1, MODE_SHL, 0, 1, 0);
        n_cmp += 2;
        if (bus4.pout !== 4'b1111) begin n_bad++; $display("FAIL en_q got=%b want=1111", bus4.pout); end
        if (bus4.frame_done !== CNT_ON) begin n_bad++; $display("FAIL en_done got=%b want=%b", bus4.frame_done, CNT_ON); end
    endtask

    task automatic test_rst_midframe();
        logic [6:0] c;
        step(1, 0, MODE_HOLD, 0, 0, 0);
        step(0, 1, MODE_SHR, 1, 0, 0);
        step(0, 1, MODE_SHR, 1, 0, 0);
        step(1, 1, MODE_SHR, 1, 0, 0);
        c = bus4.shift_cnt;
        n_cmp += 2;
        if (bus4.pout !== 4'b0000) begin n_bad++; $display("FAIL mid_rst_q got=%b want=0000", bus4.pout); end
        if (c !== 7'd0) begin n_bad++; $display("FAIL mid_rst_cnt got=%0d want=0", c); end
        for (int k = 0; k < 3; k++) begin
            step(0, 1, MODE_SHR, 0, 0, 0);
            n_cmp++;
            if (bus4.frame_done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_nodone shift=%0d got=%b want=0", k + 1, bus4.frame_done); end
        end
        step(0, 1, MODE_SHR, 0, 0, 0);
        n_cmp++;
        if (bus4.frame_done !== CNT_ON) begin n_bad++; $display("FAIL mid_rst_done got=%b want=%b", bus4.frame_done, CNT_ON); end
    endtask

    task automatic test_reserved();
        logic [3:0] snap_q;
        logic [6:0] snap_c;
        logic [6:0] c;
        step(1, 0, MODE_HOLD, 0, 0, 0);
        step(0, 1, MODE_LOAD, 0, 0, 64'($urandom_range(1, 15)));
        step(0, 1, MODE_ROR, 0, 0, 0);
        snap_q = 4'(m_q[0]);
        snap_c = 7'(e_cnt(0));
        for (int k = 0; k < 5; k++) begin
            step(0, 1, (k % 2 == 0) ? 3'b110 : 3'b111, 1, 1, 64'hF);
            c = bus4.shift_cnt;
            n_cmp += 2;
            if (bus4.pout !== snap_q) begin n_bad++; $display("FAIL rsv_q cyc=%0d got=%b want=%b", k, bus4.pout, snap_q); end
            if (c !== snap_c) begin n_bad++; $display("FAIL rsv_cnt cyc=%0d got=%0d want=%0d", k, c, snap_c); end
        end
    endtask

    task automatic test_width8();
        int pulses = 0;
        logic [6:0] c;
        step(1, 0, MODE_HOLD, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            step(0, 1, MODE_SHR, 1'($urandom), 0, 0);
            c = bus8.shift_cnt;
            if (bus8.frame_done === 1'b1) pulses++;
            n_cmp += 3;
            if (bus8.frame_done !== e_done(1)) begin n_bad++; $display("FAIL w8_done edge=%0d got=%b want=%b", k + 1, bus8.frame_done, e_done(1)); end
            if (c !== 7'(e_cnt(1))) begin n_bad++; $display("FAIL w8_cnt edge=%0d got=%0d want=%0d", k + 1, c, e_cnt(1)); end
            if (bus8.pout !== 8'(m_q[1])) begin n_bad++; $display("FAIL w8_q edge=%0d got=%h want=%h", k + 1, bus8.pout, 8'(m_q[1])); end
        end
        n_cmp++;
        if (pulses !== (CNT_ON ? 2 : 0)) begin n_bad++; $display("FAIL w8_pulses got=%0d want=%0d", pulses, CNT_ON ? 2 : 0); end
    endtask

    task automatic test_random();
        logic [6:0] c4;
        logic [6:0] c8;
        step(1, 0, MODE_HOLD, 0, 0, 0);
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) != 0), 3'($urandom),
                 1'($urandom), 1'($urandom), {$urandom, $urandom});
            c4 = bus4.shift_cnt;
            c8 = bus8.shift_cnt;
            n_cmp += 6;
            if ({bus4.sout_msb, bus4.sout_lsb, bus4.pout} !== {m_q[0][3], m_q[0][0], m_q[0][3:0]}) begin
                n_bad++; $display("FAIL rnd4_q cyc=%0d got=%b want=%b", k, bus4.pout, m_q[0][3:0]); end
            if (c4 !== 7'(e_cnt(0))) begin n_bad++; $display("FAIL rnd4_cnt cyc=%0d got=%0d want=%0d", k, c4, e_cnt(0)); end
            if (bus4.frame_done !== e_done(0)) begin n_bad++; $display("FAIL rnd4_done cyc=%0d got=%b want=%b", k, bus4.frame_done, e_done(0)); end
            if ({bus8.sout_msb, bus8.sout_lsb, bus8.pout} !== {m_q[1][7], m_q[1][0], m_q[1][7:0]}) begin
                n_bad++; $display("FAIL rnd8_q cyc=%0d got=%h want=%h", k, bus8.pout, m_q[1][7:0]); end
            if (c8 !== 7'(e_cnt(1))) begin n_bad++; $display("FAIL rnd8_cnt cyc=%0d got=%0d want=%0d", k, c8, e_cnt(1)); end
            if (bus8.frame_done !== e_done(1)) begin n_bad++; $display("FAIL rnd8_done cyc=%0d got=%b want=%b", k, bus8.frame_done, e_done(1)); end
        end
    endtask

    initial begin
        rst = 1'b0;
        bus4.en = 1'b0; bus4.mode = MODE_HOLD; bus4.sin_msb = 1'b0; bus4.sin_lsb = 1'b0; bus4.pdin = '0;
        bus8.en = 1'b0; bus8.mode = MODE_HOLD; bus8.sin_msb = 1'b0; bus8.sin_lsb = 1'b0; bus8.pdin = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_shr_serial();
        test_rotate();
        test_enable();
        test_rst_midframe();
        test_reserved();
        test_width8();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
